// File: rtl/mem_responder.sv
// mem_responder: multi-cycle unified instruction/data memory with a
// valid/ready request channel and a one-cycle response pulse.
// Programmable wait states (LATENCY) model slow memory for controller testing.
// Optional feature macro: MEM_WR_PROTECT_EN -- writes below PROT_LIM are
// dropped and flagged as faults (program region write-protected).
module mem_responder #(
   parameter int DATA_W   = 16,
   parameter int ADDR_W   = 9,
   parameter int DEPTH    = 512,
   parameter int LATENCY  = 2,
   parameter int PROT_LIM = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              req_ready,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              busy
);

   localparam int              IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [3:0]      CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
   localparam logic [ADDR_W:0] DEPTH_L  = (ADDR_W + 1)'(DEPTH);
`ifdef MEM_WR_PROTECT_EN
   localparam logic [ADDR_W:0] PROT_L   = (ADDR_W + 1)'(PROT_LIM);
`endif

   // Elaboration-time parameter sanity checks
   if (LATENCY < 0 || LATENCY > 15) begin : g_bad_latency
      $error("mem_responder: LATENCY must be 0..15 (4-bit wait counter)");
   end
   if (DEPTH < 2 || DEPTH > (1 << ADDR_W)) begin : g_bad_depth
      $error("mem_responder: DEPTH must be 2..2**ADDR_W");
   end
   if (PROT_LIM < 0 || PROT_LIM > DEPTH) begin : g_bad_prot
      $error("mem_responder: PROT_LIM must be 0..DEPTH");
   end

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t              r_state;
   logic [3:0]          r_cnt;
   logic [ADDR_W-1:0]   r_addr;
   logic                r_we;
   logic [DATA_W-1:0]   r_wdata;
   logic                r_req_ready;
   logic                r_rsp_valid;
   logic [DATA_W-1:0]   r_rsp_rdata;
   logic                r_rsp_err;
   logic                r_busy;
   logic [DATA_W-1:0]   r_mem [DEPTH];

   logic [ADDR_W-1:0]   w_addr;
   logic                w_we;
   logic                w_in_range;
   logic                w_prot;
   logic                w_err;
   logic [IDX_W-1:0]    w_idx;
   logic [DATA_W-1:0]   w_rdata;
   logic                w_commit;

   // Access decode. With LATENCY=0 the response is produced on the accept
   // edge, so in IDLE the live request is decoded; otherwise the latched one.
   always_comb begin
      w_addr     = (r_state == S_IDLE) ? req_addr : r_addr;
      w_we       = (r_state == S_IDLE) ? req_we   : r_we;
      w_in_range = ({1'b0, w_addr} < DEPTH_L);
`ifdef MEM_WR_PROTECT_EN
      w_prot     = w_we && ({1'b0, w_addr} < PROT_L);
`else
      w_prot     = 1'b0;
`endif
      w_err      = !w_in_range || w_prot;
      w_idx      = w_addr[IDX_W-1:0];
      w_rdata    = w_in_range ? r_mem[w_idx] : '0;
      // r_rsp_err already holds this access's fault flag while in RESP
      w_commit   = (r_state == S_RESP) && r_we && !r_rsp_err;
   end

   // Request/response FSM with registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_cnt       <= 4'd0;
         r_addr      <= '0;
         r_we        <= 1'b0;
         r_wdata     <= '0;
         r_req_ready <= 1'b1;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_rsp_valid <= 1'b0;
         r_rsp_err   <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (req_valid) begin
                  r_addr      <= req_addr;
                  r_we        <= req_we;
                  r_wdata     <= req_wdata;
                  r_cnt       <= CNT_INIT;
                  r_req_ready <= 1'b0;
                  r_busy      <= 1'b1;
                  if (LATENCY == 0) begin
                     r_state     <= S_RESP;
                     r_rsp_valid <= 1'b1;
                     r_rsp_err   <= w_err;
                     if (!w_we) r_rsp_rdata <= w_rdata;
                  end else begin
                     r_state <= S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               if (r_cnt == 4'd0) begin
                  r_state     <= S_RESP;
                  r_rsp_valid <= 1'b1;
                  r_rsp_err   <= w_err;
                  if (!w_we) r_rsp_rdata <= w_rdata;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            S_RESP: begin
               r_state     <= S_IDLE;
               r_req_ready <= 1'b1;
               r_busy      <= 1'b0;
            end
            default: begin
               r_state     <= S_IDLE;
               r_req_ready <= 1'b1;
               r_busy      <= 1'b0;
            end
         endcase
      end
   end

   // Store commit on the edge leaving RESP; an async reset before then
   // has already moved the FSM out of RESP, so the store is discarded.
   always_ff @(posedge clk) begin
      if (w_commit) r_mem[r_addr[IDX_W-1:0]] <= r_wdata;
   end

   assign req_ready = r_req_ready;
   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rsp_rdata;
   assign rsp_err   = r_rsp_err;
   assign busy      = r_busy;

endmodule
